// File: rtl/nn_layer_sequencer.sv
// Fully-connected layer sequencer: streams 7 weights plus a bias per neuron from a
// synchronous weight memory, accumulates in 40-bit fixed point, emits saturated results.
module nn_layer_sequencer #(
   parameter int NEURONS = 4,
   parameter int FRAC    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ce,
   input  logic               start,
   input  logic               abort,
   input  logic signed [16:0] x1,
   input  logic signed [16:0] x2,
   input  logic signed [16:0] x3,
   input  logic signed [16:0] x4,
   input  logic signed [16:0] x5,
   input  logic signed [16:0] x6,
   input  logic signed [16:0] x7,
   output logic [7:0]         w_addr,
   output logic               w_en,
   input  logic signed [16:0] w_data,
   output logic               busy,
   output logic               y_valid,
   output logic [3:0]         y_idx,
   output logic signed [16:0] y_out,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

   localparam logic signed [39:0] SAT_HI = 40'sd65535;
   localparam logic signed [39:0] SAT_LO = -40'sd65536;

   state_t             state_q, state_d;
   logic [3:0]         n_q, n_d;
   logic [2:0]         i_q, i_d;
   logic signed [39:0] acc_q, acc_d;
   logic [3:0]         y_idx_q, y_idx_d;
   logic signed [16:0] y_out_q, y_out_d;
   logic               load_x;

   logic signed [16:0] x_in [7];
   logic signed [16:0] x_q  [7];
   logic signed [16:0] x_sel;
   logic signed [33:0] prod;
   logic signed [39:0] prod_ext;
   logic signed [39:0] bias_ext;
   logic signed [39:0] bias;
   logic signed [39:0] acc_shr;
   logic signed [16:0] y_sat;

   assign x_in[0] = x1;
   assign x_in[1] = x2;
   assign x_in[2] = x3;
   assign x_in[3] = x4;
   assign x_in[4] = x5;
   assign x_in[5] = x6;
   assign x_in[6] = x7;

   // Inputs are captured once at start so a run sees a stable operand set.
   for (genvar gi = 0; gi < 7; gi++) begin : g_xlatch
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            x_q[gi] <= '0;
         end else if (ce && load_x) begin
            x_q[gi] <= x_in[gi];
         end
      end
   end

   // w_data lags the address by one cycle, so index i pairs with x(i-1).
   always_comb begin
      x_sel = '0;
      case (i_q)
         3'd1:    x_sel = x_q[0];
         3'd2:    x_sel = x_q[1];
         3'd3:    x_sel = x_q[2];
         3'd4:    x_sel = x_q[3];
         3'd5:    x_sel = x_q[4];
         3'd6:    x_sel = x_q[5];
         3'd7:    x_sel = x_q[6];
         default: x_sel = '0;
      endcase
   end

   assign prod     = $signed({{17{x_sel[16]}}, x_sel}) * $signed({{17{w_data[16]}}, w_data});
   assign prod_ext = {{6{prod[33]}}, prod};
   assign bias_ext = {{23{w_data[16]}}, w_data};
   assign bias     = bias_ext <<< FRAC;
   assign acc_shr  = acc_q >>> FRAC;

   always_comb begin
      if (acc_shr > SAT_HI) begin
         y_sat = 17'h0FFFF;
      end else if (acc_shr < SAT_LO) begin
         y_sat = 17'h10000;
      end else begin
         y_sat = acc_shr[16:0];
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      i_d     = i_q;
      acc_d   = acc_q;
      y_idx_d = y_idx_q;
      y_out_d = y_out_q;
      load_x  = 1'b0;
      w_en    = 1'b0;
      y_valid = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = FETCH;
               n_d     = '0;
               i_d     = '0;
               acc_d   = '0;
               load_x  = 1'b1;
            end
         end
         FETCH: begin
            w_en = ce;
            if (i_q != 3'd0) begin
               acc_d = acc_q + prod_ext;
            end
            if (i_q == 3'd7) begin
               state_d = DRAIN;
            end else begin
               i_d = i_q + 3'd1;
            end
         end
         DRAIN: begin
            acc_d   = acc_q + bias;
            state_d = OUT;
         end
         OUT: begin
            y_valid = ce;
            y_idx_d = n_q;
            y_out_d = y_sat;
            acc_d   = '0;
            i_d     = '0;
            if (n_q == 4'(NEURONS - 1)) begin
               done    = ce;
               n_d     = '0;
               state_d = IDLE;
            end else begin
               n_d     = n_q + 4'd1;
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort discards the run without publishing anything.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         n_d     = '0;
         i_d     = '0;
         acc_d   = '0;
         y_idx_d = y_idx_q;
         y_out_d = y_out_q;
         y_valid = 1'b0;
         done    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         i_q     <= '0;
         acc_q   <= '0;
         y_idx_q <= '0;
         y_out_q <= '0;
      end else if (ce) begin
         state_q <= state_d;
         n_q     <= n_d;
         i_q     <= i_d;
         acc_q   <= acc_d;
         y_idx_q <= y_idx_d;
         y_out_q <= y_out_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign w_addr = {1'b0, n_q, i_q};
   // Results are live during OUT and hold their last published value elsewhere.
   assign y_idx  = (state_q == OUT) ? n_q : y_idx_q;
   assign y_out  = (state_q == OUT) ? y_sat : y_out_q;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: directed and randomized layer runs
// compared against an arithmetic reference of the layer equations.
module tb_nn_layer_sequencer;

   localparam int NEURONS = 2;
   localparam int FRAC    = 8;

   logic               clk = 1'b0;
   logic               rst_n, ce, start, abort;
   logic signed [16:0] x1, x2, x3, x4, x5, x6, x7;
   logic [7:0]         w_addr;
   logic               w_en;
   logic signed [16:0] w_data;
   logic               busy, y_valid, done;
   logic [3:0]         y_idx;
   logic signed [16:0] y_out;

   int mem_i [256];
   int xv [7];
   int n_pass   = 0;
   int n_checks = 0;
   int last_y   = 0;
   int last_idx = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (w_en) w_data <= 17'(mem_i[w_addr]);
   end

   nn_layer_sequencer #(.NEURONS(NEURONS), .FRAC(FRAC)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .abort(abort),
      .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
      .w_addr(w_addr), .w_en(w_en), .w_data(w_data),
      .busy(busy), .y_valid(y_valid), .y_idx(y_idx), .y_out(y_out), .done(done)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Reference: y = clamp((sum x_k*w_k + bias*2^FRAC) >> FRAC)
   function automatic int ref_y(input int n);
      longint acc = 0;
      for (int k = 0; k < 7; k++) acc += longint'(xv[k]) * longint'(mem_i[n*8+k]);
      acc += longint'(mem_i[n*8+7]) * (longint'(1) << FRAC);
      acc = acc >>> FRAC;
      if (acc > 65535) return 65535;
      if (acc < -65536) return -65536;
      return int'(acc);
   endfunction

   task automatic drive_x();
      x1 = 17'(xv[0]); x2 = 17'(xv[1]); x3 = 17'(xv[2]); x4 = 17'(xv[3]);
      x5 = 17'(xv[4]); x6 = 17'(xv[5]); x7 = 17'(xv[6]);
   endtask

   task automatic drive_x_random();
      x1 = 17'($urandom); x2 = 17'($urandom); x3 = 17'($urandom); x4 = 17'($urandom);
      x5 = 17'($urandom); x6 = 17'($urandom); x7 = 17'($urandom);
   endtask

   task automatic set_all(input int xval, input int wval, input int bval);
      for (int k = 0; k < 7; k++) xv[k] = xval;
      for (int n = 0; n < NEURONS; n++) begin
         for (int k = 0; k < 7; k++) mem_i[n*8+k] = wval;
         mem_i[n*8+7] = bval;
      end
   endtask

   task automatic set_rand(input int range);
      for (int k = 0; k < 7; k++) xv[k] = int'($urandom_range(0, 2*range-1)) - range;
      for (int a = 0; a < NEURONS*8; a++) mem_i[a] = int'($urandom_range(0, 2*range-1)) - range;
   endtask

   // ce_mode: 0 always enabled, 1 five-cycle stall at stall_at, 2 random ce
   task automatic run_layer(input int ce_mode, input int stall_at, input int abort_at, input bit busy_start);
      int  en_done = 0;
      int  guard   = 0;
      int  stalled = 0;
      int  pos, nidx, exp_y;
      bit  aborted = 0;
      bit  exp_valid;
      @(negedge clk);
      drive_x();
      start = 1'b1; abort = 1'b0; ce = 1'b1;
      #1;
      chk("busy_before_start", busy, 0);
      while (en_done < NEURONS*10 && !aborted) begin
         @(negedge clk);
         pos  = en_done % 10;
         nidx = en_done / 10;
         start = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
         if (busy_start) drive_x_random();
         if (ce_mode == 1) begin
            if (en_done == stall_at && stalled < 5) begin
               ce = 1'b0;
               stalled++;
            end else begin
               ce = 1'b1;
            end
         end else if (ce_mode == 2) begin
            ce = ($urandom_range(0, 3) != 0);
         end else begin
            ce = 1'b1;
         end
         abort = (en_done == abort_at);
         if (abort) ce = 1'b1;
         #1;
         exp_valid = ce && !abort && pos == 9;
         exp_y = ref_y(nidx);
         chk("busy", busy, 1);
         chk("y_valid", y_valid, 32'(exp_valid));
         chk("done", done, 32'(exp_valid && nidx == NEURONS-1));
         chk("w_en", w_en, 32'(ce && pos < 8));
         if (pos < 8) chk("w_addr", w_addr, nidx*8 + pos);
         if (pos == 9) begin
            chk("y_out", y_out, exp_y);
            chk("y_idx", y_idx, nidx);
         end else begin
            chk("y_out_hold", y_out, last_y);
            chk("y_idx_hold", y_idx, last_idx);
         end
         if (ce) begin
            if (abort) begin
               aborted = 1;
            end else begin
               if (pos == 9) begin
                  last_y   = exp_y;
                  last_idx = nidx;
               end
               en_done++;
            end
         end
         guard++;
         if (guard > 1000) begin
            n_checks++;
            $error("FAIL timeout observed=%0d expected=%0d enabled cycles", en_done, NEURONS*10);
            break;
         end
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; ce = 1'b1;
      #1;
      chk("busy_after", busy, 0);
      chk("y_valid_after", y_valid, 0);
      chk("done_after", done, 0);
      chk("w_en_after", w_en, 0);
      chk("y_out_after", y_out, last_y);
      chk("y_idx_after", y_idx, last_idx);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_y_valid"}, y_valid, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_w_en"}, w_en, 0);
      chk({tag, "_w_addr"}, w_addr, 0);
      chk({tag, "_y_idx"}, y_idx, 0);
      chk({tag, "_y_out"}, y_out, 0);
   endtask

   initial begin
      rst_n = 1'b1; ce = 1'b0; start = 1'b0; abort = 1'b0;
      set_all(0, 0, 0);
      drive_x();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      set_all(256, 256, 128);
      run_layer(0, -1, -1, 0);
      set_all(32512, 32512, 0);
      run_layer(0, -1, -1, 0);
      set_all(32512, -32512, 0);
      run_layer(0, -1, -1, 0);
      set_rand(2048);
      run_layer(0, -1, -1, 0);
      set_rand(65536);
      run_layer(0, -1, -1, 0);

      set_rand(4096);
      run_layer(1, 3, -1, 0);

      set_rand(4096);
      run_layer(0, -1, 14, 0);
      set_rand(4096);
      run_layer(0, -1, -1, 0);

      set_rand(4096);
      run_layer(0, -1, -1, 1);

      @(negedge clk);
      start = 1'b1; abort = 1'b1; ce = 1'b1;
      #1 chk("start_abort_busy_now", busy, 0);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      #1 chk("start_abort_busy_next", busy, 0);
      chk("start_abort_w_en", w_en, 0);

      set_rand(4096);
      run_layer(2, -1, -1, 0);

      set_rand(4096);
      @(negedge clk);
      drive_x();
      start = 1'b1; ce = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      ce = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk_all_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1; ce = 1'b1;
      last_y = 0; last_idx = 0;
      repeat (3) begin
         @(negedge clk);
         #1 chk("post_reset_idle", busy, 0);
      end
      run_layer(0, -1, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 SHALL have parameter NEURONS, default 4; number of neurons in the layer (1..16).
REQ-002 SHALL have parameter FRAC, default 8; fractional bits of all signed fixed-point values.
REQ-003 SHALL have port clk, input, 1; single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1; clock enable; ce=0 freezes all state.
REQ-006 SHALL have port start, input, 1; request to evaluate the layer.
REQ-007 SHALL have port abort, input, 1; cancel the evaluation in progress.
REQ-008 SHALL have ports x1..x7, input, 17 each; signed layer inputs.
REQ-009 SHALL have port w_addr, output, 8; weight-memory word address.
REQ-010 SHALL have port w_en, output, 1; weight-memory read enable.
REQ-011 SHALL have port w_data, input, 17; signed weight, valid the cycle after an enabled read, held otherwise.
REQ-012 SHALL have port busy, output, 1; high in any state other than IDLE.
REQ-013 SHALL have port y_valid, output, 1; neuron result strobe.
REQ-014 SHALL have port y_idx, output, 4; index of the neuron whose result is on y_out.
REQ-015 SHALL have port y_out, output, 17; signed, saturated neuron pre-activation.
REQ-016 SHALL have port done, output, 1; layer-complete strobe.

Function
REQ-017 SHALL implement FSM IDLE, FETCH, DRAIN, OUT; every register update SHALL occur only on edges with ce=1.
REQ-018 In IDLE with start=1 and abort=0, x1..x7 SHALL be latched, neuron n=0, input index i=0, acc=0, next state FETCH.
REQ-019 In FETCH, w_en=ce and w_addr=n*8+i; i SHALL step 0..7; at i=7 next state DRAIN.
REQ-020 In FETCH with i>=1 and in DRAIN, acc SHALL add the product of x(i-1) and w_data for input indices 0..6, and w_data<<FRAC for index 7 (bias).
REQ-021 acc SHALL be signed 40-bit; products SHALL be full-precision 34-bit signed, sign-extended.
REQ-022 DRAIN SHALL last one cycle, then OUT.
REQ-023 In OUT, y_valid=ce, y_idx=n, and y_out=clamp(acc>>>FRAC, -65536, 65535).
REQ-024 On leaving OUT, acc SHALL clear; if n=NEURONS-1, done=ce in the same cycle and the next state is IDLE; otherwise n increments, i=0, and the next state is FETCH.
REQ-025 Each neuron SHALL take exactly 10 ce-enabled cycles; the first y_valid SHALL occur 10 enabled cycles after start is accepted.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 abort=1 with ce=1 in any non-IDLE state SHALL return the FSM to IDLE next edge with no y_valid and no done.
REQ-028 If start and abort are both 1 in IDLE, abort SHALL win and start SHALL be ignored.
REQ-029 Latched x values SHALL NOT change during a run, even if x1..x7 change.
REQ-030 y_out and y_idx SHALL hold their last values outside OUT.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, n=0, i=0, acc=0, w_addr=0, w_en=0, busy=0, y_valid=0, done=0, y_idx=0, y_out=0, regardless of ce.
REQ-032 Reset asserted mid-run SHALL discard the run; after release, the block SHALL wait for a new start.

Verification
REQ-033 Reset: rst_n=0 at any cycle -> all outputs 0 asynchronously, with no clock edge required.
REQ-034 NEURONS=2, FRAC=8, all x=256, weights at indices 0..6=256, bias=128 -> y_idx 0 y_out=1920 at cycle 10 and y_idx 1 y_out=1920 at cycle 20, with done at cycle 20.
REQ-035 Saturation: all x=32512, all weights=32512, bias=0 -> y_out=65535; negate all weights -> y_out=-65536.
REQ-036 ce held 0 for 5 cycles mid-FETCH -> identical y_out values, every strobe delayed by exactly 5 cycles, w_addr frozen.
REQ-037 abort at cycle 4 of neuron 1 -> busy=0 next cycle, no further y_valid and no done; a following start yields a full correct run.
REQ-038 start pulsed while busy, and start+abort together in IDLE -> both ignored; the run in progress is unaffected.
